sccb_config_sequencer: RTL and testbench

- Power-up and register-configuration controller for the OV7670 camera; sits between the debounced resend button and the SCCB (I2C-like) write master.
- Controls the camera power-down and reset pins, then walks a register table, issuing one write per entry over a request/done handshake.
- Asserts config_finished when the table is complete.
- Replaces the hard-wired sequencing inside the camera controller so the register table and timing are independent of the bus master.

---
 rtl/sccb_config_sequencer_pkg.sv | 23 ++
 rtl/sccb_config_sequencer_rom.sv | 82 ++++++++
 rtl/sccb_config_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_sccb_config_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_config_sequencer_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        PWR_DN    = 3'd0,
        RST_HOLD  = 3'd1,
        RST_WAIT  = 3'd2,
        FETCH     = 3'd3,
        ISSUE     = 3'd4,
        GAP       = 3'd5,
        SOFT_WAIT = 3'd6,
        DONE      = 3'd7
    } seq_state_t;

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [7:0]  COM7_ADDR    = 8'h12;
    localparam int unsigned SOFT_RST_BIT = 7;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sccb_config_sequencer_rom.sv
// OV7670 register table as a synchronous ROM: {addr, data} per entry, one-cycle read latency.
// ROM_SEL=1 selects a short bring-up table (soft reset, clock divider, output format).
module ov7670_reg_rom
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned AW      = 6,
    parameter bit          ROM_SEL = 1'b0
)(
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    output logic [15:0]   o_data
);

    logic [15:0] r_data;
    logic [15:0] w_entry;
    logic [7:0]  w_idx;

    assign w_idx = 8'(i_addr);

    always_comb begin
        w_entry = END_MARKER;
        if (ROM_SEL) begin
            case (w_idx)
                8'd0:    w_entry = 16'h1280;
                8'd1:    w_entry = 16'h1101;
                8'd2:    w_entry = 16'h40D0;
                default: w_entry = END_MARKER;
            endcase
        end else begin
            // QVGA, RGB output; RGB332 is taken from the top bits of RGB565 downstream
            case (w_idx)
                8'd0:    w_entry = 16'h1280;
                8'd1:    w_entry = 16'h1280;
                8'd2:    w_entry = 16'h1214;
                8'd3:    w_entry = 16'h1100;
                8'd4:    w_entry = 16'h0C04;
                8'd5:    w_entry = 16'h3E19;
                8'd6:    w_entry = 16'h0400;
                8'd7:    w_entry = 16'h40D0;
                8'd8:    w_entry = 16'h3A04;
                8'd9:    w_entry = 16'h1418;
                8'd10:   w_entry = 16'h703A;
                8'd11:   w_entry = 16'h7135;
                8'd12:   w_entry = 16'h7211;
                8'd13:   w_entry = 16'h73F1;
                8'd14:   w_entry = 16'hA202;
                8'd15:   w_entry = 16'h4FB3;
                8'd16:   w_entry = 16'h50B3;
                8'd17:   w_entry = 16'h5100;
                8'd18:   w_entry = 16'h523D;
                8'd19:   w_entry = 16'h53A7;
                8'd20:   w_entry = 16'h54E4;
                8'd21:   w_entry = 16'h589E;
                8'd22:   w_entry = 16'h3DC0;
                8'd23:   w_entry = 16'h1716;
                8'd24:   w_entry = 16'h1804;
                8'd25:   w_entry = 16'h3224;
                8'd26:   w_entry = 16'h1902;
                8'd27:   w_entry = 16'h1A7A;
                8'd28:   w_entry = 16'h030A;
                8'd29:   w_entry = 16'h0F41;
                8'd30:   w_entry = 16'h1E00;
                8'd31:   w_entry = 16'h330B;
                8'd32:   w_entry = 16'h3C78;
                8'd33:   w_entry = 16'h6900;
                8'd34:   w_entry = 16'h7400;
                8'd35:   w_entry = 16'hB084;
                8'd36:   w_entry = 16'hB10C;
                8'd37:   w_entry = 16'hB20E;
                8'd38:   w_entry = 16'hB380;
                default: w_entry = END_MARKER;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        r_data <= w_entry;
    end

    assign o_data = r_data;

endmodule

// File: rtl/sccb_config_sequencer.sv
// OV7670 power-up and register-table sequencer driving an SCCB write master.
// Optional wr_done watchdog in ISSUE: define SCCB_SEQ_TIMEOUT_EN (timeout handled as a NACK).
//
// state     | meaning
// PWR_DN    | camera powered down, held in reset
// RST_HOLD  | powered up, still held in reset
// RST_WAIT  | reset released, settling
// FETCH     | table entry read back, decide issue or finish
// ISSUE     | wr_req high until wr_done
// GAP       | idle spacing between writes
// SOFT_WAIT | settle after a COM7 soft-reset write
// DONE      | table complete
module sccb_config_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS          = 64,
    parameter int unsigned PWR_WAIT_CYC      = 25000,
    parameter int unsigned SOFT_RST_WAIT_CYC = 25000,
    parameter int unsigned GAP_CYC           = 16,
    parameter int unsigned MAX_RETRY         = 3,
    parameter int unsigned TIMEOUT_CYC       = 4096,
    parameter bit          ROM_SEL           = 1'b0,
    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_resend,
    output logic          o_cam_pwdn,
    output logic          o_cam_reset,
    output logic          o_wr_req,
    output logic [7:0]    o_wr_addr,
    output logic [7:0]    o_wr_data,
    input  logic          i_wr_done,
    input  logic          i_wr_nack,
    output logic          o_config_finished,
    output logic          o_config_error,
    output logic          o_busy,
    output logic [IW-1:0] o_cur_index
);

    localparam int unsigned CNT_MAX = umax(umax(PWR_WAIT_CYC, SOFT_RST_WAIT_CYC),
                                           umax(GAP_CYC, TIMEOUT_CYC));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t  r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [IW:0]   r_index, w_index_nxt;
    logic [RW-1:0] r_retry, w_retry_nxt;
    logic          r_soft, w_soft_nxt;
    logic          r_pend, w_pend_nxt;
    logic          r_error, w_error_nxt;
    logic [7:0]    r_wr_addr, w_addr_nxt;
    logic [7:0]    r_wr_data, w_data_nxt;
    logic          r_cam_pwdn, r_cam_reset, r_wr_req, r_finished, r_busy;
    logic [15:0]   w_rom_data;
    logic          w_cnt_zero;
    logic          w_timeout;

    function automatic logic [CW-1:0] cnt_load(input seq_state_t s);
        case (s)
            PWR_DN, RST_HOLD, RST_WAIT: cnt_load = CW'(PWR_WAIT_CYC - 1);
            GAP:                        cnt_load = CW'(GAP_CYC - 1);
            SOFT_WAIT:                  cnt_load = CW'(SOFT_RST_WAIT_CYC - 1);
`ifdef SCCB_SEQ_TIMEOUT_EN
            ISSUE:                      cnt_load = CW'(TIMEOUT_CYC - 1);
`endif
            default:                    cnt_load = '0;
        endcase
    endfunction

    // ROM is addressed by the next index so the entry is valid in the first FETCH cycle
    ov7670_reg_rom #(
        .AW      (IW),
        .ROM_SEL (ROM_SEL)
    ) u_rom (
        .i_clk  (i_clk),
        .i_addr (w_index_nxt[IW-1:0]),
        .o_data (w_rom_data)
    );

    assign w_cnt_zero = (r_cnt == '0);

`ifdef SCCB_SEQ_TIMEOUT_EN
    assign w_timeout = (r_state == ISSUE) && w_cnt_zero && !i_wr_done;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= PWR_DN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_retry_nxt = r_retry;
        w_soft_nxt  = r_soft;
        w_pend_nxt  = r_pend;
        w_error_nxt = r_error;
        w_addr_nxt  = r_wr_addr;
        w_data_nxt  = r_wr_data;

        if (i_resend && (r_state inside {FETCH, ISSUE, GAP, SOFT_WAIT})) begin
            w_pend_nxt = 1'b1;
        end

        case (r_state)
            PWR_DN: begin
                if (w_cnt_zero) w_state_nxt = RST_HOLD;
            end
            RST_HOLD: begin
                if (w_cnt_zero) w_state_nxt = RST_WAIT;
            end
            RST_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = FETCH;
                    w_index_nxt = '0;
                end
            end
            FETCH: begin
                // A pending resend restarts here; one extra FETCH cycle re-reads entry 0
                if (r_pend) begin
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                    w_error_nxt = 1'b0;
                    w_pend_nxt  = 1'b0;
                end else if ((r_index == (IW+1)'(NUM_REGS)) || (w_rom_data == END_MARKER)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_addr_nxt  = w_rom_data[15:8];
                    w_data_nxt  = w_rom_data[7:0];
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (i_wr_done && !i_wr_nack) begin
                    w_retry_nxt = '0;
                    w_index_nxt = r_index + 1'b1;
                    w_soft_nxt  = (r_wr_addr == COM7_ADDR) && r_wr_data[SOFT_RST_BIT];
                    w_state_nxt = GAP;
                end else if (i_wr_done || w_timeout) begin
                    w_soft_nxt = 1'b0;
                    if (r_retry < RW'(MAX_RETRY)) begin
                        w_retry_nxt = r_retry + 1'b1;
                    end else begin
                        w_retry_nxt = '0;
                        w_error_nxt = 1'b1;
                        w_index_nxt = r_index + 1'b1;
                    end
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = r_soft ? SOFT_WAIT : FETCH;
                    w_soft_nxt  = 1'b0;
                end
            end
            SOFT_WAIT: begin
                if (w_cnt_zero) w_state_nxt = FETCH;
            end
            DONE: begin
                if (i_resend) begin
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                    w_error_nxt = 1'b0;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = PWR_DN;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = cnt_load(w_state_nxt);
        end else if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= cnt_load(PWR_DN);
            r_index     <= '0;
            r_retry     <= '0;
            r_soft      <= 1'b0;
            r_pend      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cam_pwdn  <= 1'b1;
            r_cam_reset <= 1'b0;
            r_wr_req    <= 1'b0;
            r_finished  <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_index     <= w_index_nxt;
            r_retry     <= w_retry_nxt;
            r_soft      <= w_soft_nxt;
            r_pend      <= w_pend_nxt;
            r_error     <= w_error_nxt;
            r_wr_addr   <= w_addr_nxt;
            r_wr_data   <= w_data_nxt;
            r_cam_pwdn  <= (w_state_nxt == PWR_DN);
            r_cam_reset <= !(w_state_nxt inside {PWR_DN, RST_HOLD});
            r_wr_req    <= (w_state_nxt == ISSUE);
            r_finished  <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != DONE);
        end
    end

    assign o_cam_pwdn        = r_cam_pwdn;
    assign o_cam_reset       = r_cam_reset;
    assign o_wr_req          = r_wr_req;
    assign o_wr_addr         = r_wr_addr;
    assign o_wr_data         = r_wr_data;
    assign o_config_finished = r_finished;
    assign o_config_error    = r_error;
    assign o_busy            = r_busy;
    assign o_cur_index       = r_index[IW-1:0];

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Scoreboard bench for sccb_config_sequencer using the short bring-up table.
module tb_sccb_config_sequencer;

    localparam int unsigned PWR  = 10;
    localparam int unsigned SOFT = 20;
    localparam int unsigned GAPC = 2;
    localparam int unsigned TOC  = 50;

    logic       i_clk, i_rst, i_resend, i_wr_done, i_wr_nack;
    logic       o_cam_pwdn, o_cam_reset, o_wr_req, o_config_finished, o_config_error, o_busy;
    logic [7:0] o_wr_addr, o_wr_data;
    logic [5:0] o_cur_index;

    int n_cmp = 0;
    int n_err = 0;
    int n_req = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int pwr_glitch = 0;
    int nack_left = 0;
    bit resp_en = 1'b1;
    bit watch_pwr = 1'b0;
    logic [15:0] exp_q[$];
    int gap_q[$];

    sccb_config_sequencer #(
        .NUM_REGS          (64),
        .PWR_WAIT_CYC      (PWR),
        .SOFT_RST_WAIT_CYC (SOFT),
        .GAP_CYC           (GAPC),
        .MAX_RETRY         (1),
        .TIMEOUT_CYC       (TOC),
        .ROM_SEL           (1'b1)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_resend          (i_resend),
        .o_cam_pwdn        (o_cam_pwdn),
        .o_cam_reset       (o_cam_reset),
        .o_wr_req          (o_wr_req),
        .o_wr_addr         (o_wr_addr),
        .o_wr_data         (o_wr_data),
        .i_wr_done         (i_wr_done),
        .i_wr_nack         (i_wr_nack),
        .o_config_finished (o_config_finished),
        .o_config_error    (o_config_error),
        .o_busy            (o_busy),
        .o_cur_index       (o_cur_index)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: pops the expected write on each wr_req rise, answers 3 cycles later
    initial begin : responder
        logic        prev_req;
        logic [15:0] cur_exp;
        int          resp_cnt;
        prev_req  = 1'b0;
        cur_exp   = '0;
        resp_cnt  = 0;
        i_wr_done = 1'b0;
        i_wr_nack = 1'b0;
        forever begin
            @(negedge i_clk);
            cyc++;
            i_wr_done = 1'b0;
            i_wr_nack = 1'b0;
            if (watch_pwr && (o_cam_pwdn || !o_cam_reset)) pwr_glitch++;
            if (i_rst) begin
                prev_req = 1'b0;
                resp_cnt = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        chk("wr_stable", {o_wr_addr, o_wr_data}, cur_exp);
                        i_wr_done = 1'b1;
                        if (nack_left > 0 && o_wr_addr == 8'h11) begin
                            i_wr_nack = 1'b1;
                            nack_left--;
                        end
                        last_done_cyc = cyc;
                    end
                end
                if (o_wr_req && !prev_req) begin
                    n_req++;
                    gap_q.push_back(cyc - last_done_cyc);
                    chk("req_has_expect", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur_exp = exp_q.pop_front();
                        chk("wr_addr_data", {o_wr_addr, o_wr_data}, cur_exp);
                    end
                    if (resp_en) resp_cnt = 3;
                end
                prev_req = o_wr_req;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pwdn"},  o_cam_pwdn, 1);
        chk({tag, "_camrst"}, o_cam_reset, 0);
        chk({tag, "_req"},   o_wr_req, 0);
        chk({tag, "_addr"},  o_wr_addr, 0);
        chk({tag, "_data"},  o_wr_data, 0);
        chk({tag, "_fin"},   o_config_finished, 0);
        chk({tag, "_err"},   o_config_error, 0);
        chk({tag, "_busy"},  o_busy, 1);
        chk({tag, "_idx"},   o_cur_index, 0);
    endtask

    // Called on the negedge where rst is released
    task automatic power_seq(input string tag);
        int n_dn = 0;
        int n_hold = 0;
        int n_lat = 0;
        while (o_cam_pwdn && !o_cam_reset && n_dn < 200) begin
            n_dn++;
            @(negedge i_clk);
        end
        while (!o_cam_pwdn && !o_cam_reset && n_hold < 200) begin
            n_hold++;
            @(negedge i_clk);
        end
        while (!o_wr_req && o_cam_reset && !o_cam_pwdn && n_lat < 200) begin
            n_lat++;
            @(negedge i_clk);
        end
        chk({tag, "_pwdn_cycles"}, n_dn, PWR);
        chk({tag, "_hold_cycles"}, n_hold, PWR);
        chk({tag, "_first_req_lat_ok"}, 32'(n_lat >= PWR && n_lat <= PWR + 2), 1);
    endtask

    task automatic wait_fin(input string tag, input int budget);
        int k = 0;
        while (!o_config_finished && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        chk(tag, o_config_finished, 1);
    endtask

    task automatic pulse_resend();
        i_resend = 1'b1;
        @(negedge i_clk);
        i_resend = 1'b0;
    endtask

    initial begin : main
        int base_req;
        int base_gap;
        int base_glitch;
        int k;
        i_rst    = 1'b1;
        i_resend = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_vals("por");

        // Power-up, soft-reset settle, all ACK
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h40D0);
        base_req = n_req;
        base_gap = gap_q.size();
        i_rst = 1'b0;
        power_seq("pu");
        wait_fin("t2_finished", 2000);
        chk("t2_busy", o_busy, 0);
        chk("t2_err", o_config_error, 0);
        chk("t2_reqs", n_req - base_req, 3);
        chk("t2_queue_empty", exp_q.size(), 0);
        chk("t2_cur_index", o_cur_index, 3);
        chk("t2_soft_gap_ge22", 32'(gap_q[base_gap + 1] >= 22), 1);
        chk("t2_plain_gap", gap_q[base_gap + 2], GAPC + 2);

        // Resend from DONE with two NACKs on 11/01: retry once, then skip
        watch_pwr   = 1'b1;
        base_glitch = pwr_glitch;
        nack_left   = 2;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h40D0);
        base_req = n_req;
        @(negedge i_clk);
        pulse_resend();
        chk("t3_fin_clear", o_config_finished, 0);
        chk("t3_busy", o_busy, 1);
        wait_fin("t3_finished", 2000);
        chk("t3_err", o_config_error, 1);
        chk("t3_reqs", n_req - base_req, 4);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Resend from DONE clears the error; a second resend during 11/01 restarts after it
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h40D0);
        base_req = n_req;
        pulse_resend();
        chk("t4_err_clear", o_config_error, 0);
        chk("t4_fin_clear", o_config_finished, 0);
        k = 0;
        while (!(o_wr_req && o_wr_addr == 8'h11) && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("t4_saw_11_req", o_wr_req, 1);
        pulse_resend();
        wait_fin("t4_finished", 2000);
        chk("t4_err", o_config_error, 0);
        chk("t4_reqs", n_req - base_req, 5);
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t34_no_pwr_toggle", pwr_glitch - base_glitch, 0);
        watch_pwr = 1'b0;

        // Async reset while wr_req is high
        exp_q.push_back(16'h1280);
        pulse_resend();
        k = 0;
        while (!o_wr_req && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        chk("t5_req_seen", o_wr_req, 1);
        #1 i_rst = 1'b1;
        #1 chk("t5_req_async_drop", o_wr_req, 0);
        check_reset_vals("mid");
        repeat (2) @(negedge i_clk);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h40D0);
        base_req = n_req;
        i_rst = 1'b0;
        power_seq("rpu");
        wait_fin("t5_finished", 2000);
        chk("t5_reqs", n_req - base_req, 3);
        chk("t5_queue_empty", exp_q.size(), 0);

`ifdef SCCB_SEQ_TIMEOUT_EN
        // Slave never answers: each entry times out, retried once, then skipped
        resp_en = 1'b0;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h1101);
        exp_q.push_back(16'h40D0);
        exp_q.push_back(16'h40D0);
        base_req = n_req;
        @(negedge i_clk);
        pulse_resend();
        k = 0;
        while (!o_wr_req && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        k = 0;
        while (o_wr_req && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        chk("t6_req_len", k, TOC);
        wait_fin("t6_finished", 3000);
        chk("t6_err", o_config_error, 1);
        chk("t6_reqs", n_req - base_req, 6);
        chk("t6_queue_empty", exp_q.size(), 0);
        resp_en = 1'b1;
`endif

        repeat (2) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach the end, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
